pipe_array_mul: RTL and testbench

- Parametrised, fully pipelined array multiplier, WIDTH x WIDTH -> 2*WIDTH.
- Selects unsigned or two's-complement signed mode per operation.
- Uses a valid/ready handshake on both sides, accepts one operation per cycle, and stalls the whole pipeline under output backpressure.
- Serves as the general multiply engine for datapath blocks that need throughput-1 products at configurable width and latency, replacing fixed 4-bit multipliers.

---
 rtl/mul_pkg.sv | 20 ++
 rtl/mul_pp_stage.sv | 36 +++
 rtl/pipe_array_mul.sv | 85 ++++++++
 tb/tb_pipe_array_mul.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared helpers for the pipelined array multiplier:
// stage counting, per-stage row counts and latency.
package mul_pkg;

    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    function automatic int mul_latency(input int w, input int rps);
        return ceil_div(w, rps) + 1;
    endfunction

    // Rows handled by compute stage k (1-based); the last may be partial.
    function automatic int stage_rows(input int w, input int rps, input int k);
        int rem;
        rem = w - (k - 1) * rps;
        return (rem < rps) ? rem : rps;
    endfunction

endpackage

// File: rtl/mul_pp_stage.sv
// Combinational sum of a group of partial-product rows into the accumulator.
// The row at multiplier bit WIDTH-1 carries negative weight in signed mode.
module mul_pp_stage #(
    parameter int WIDTH = 8,
    parameter int ROWS  = 2,
    parameter int OFF   = 0
) (
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [ROWS-1:0]    b,
    input  logic [2*WIDTH-1:0] acc_in,
    output logic [2*WIDTH-1:0] acc_out
);

    localparam int PW = 2 * WIDTH;

    logic [PW-1:0] aext;
    logic [PW-1:0] row;
    logic [PW-1:0] sum;

    assign aext = {{WIDTH{sgn & a[WIDTH-1]}}, a};

    always_comb begin
        sum = acc_in;
        row = '0;
        for (int i = 0; i < ROWS; i++) begin
            row = b[i] ? (aext << (OFF + i)) : '0;
            if (sgn && (OFF + i == WIDTH - 1))
                sum = sum - row;
            else
                sum = sum + row;
        end
        acc_out = sum;
    end

endmodule

// File: rtl/pipe_array_mul.sv
// Fully pipelined WIDTH x WIDTH array multiplier, signed/unsigned per op,
// valid/ready on both sides with whole-pipeline stall on backpressure.
module pipe_array_mul
    import mul_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int ROWS_PER_STAGE = 2,
    parameter int TAG_W          = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   din_a,
    input  logic [WIDTH-1:0]   din_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] dout,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int NCS = ceil_div(WIDTH, ROWS_PER_STAGE);
    localparam int PW  = 2 * WIDTH;

    typedef struct packed {
        logic             valid;
        logic             sgn;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [PW-1:0]    acc;
    } stage_t;

    // st[0] is the operand capture stage; compute stage NCS writes the outputs.
    stage_t        st [NCS];
    logic [PW-1:0] pp [NCS];
    logic          adv;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    for (genvar k = 1; k <= NCS; k++) begin : g_pp
        localparam int NR  = stage_rows(WIDTH, ROWS_PER_STAGE, k);
        localparam int OFS = (k - 1) * ROWS_PER_STAGE;

        mul_pp_stage #(
            .WIDTH (WIDTH),
            .ROWS  (NR),
            .OFF   (OFS)
        ) u_pp (
            .sgn     (st[k-1].sgn),
            .a       (st[k-1].a),
            .b       (st[k-1].b[OFS +: NR]),
            .acc_in  (st[k-1].acc),
            .acc_out (pp[k-1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NCS; k++)
                st[k].valid <= 1'b0;
            out_valid <= 1'b0;
            dout      <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            st[0].valid <= in_valid;
            st[0].sgn   <= in_signed;
            st[0].tag   <= in_tag;
            st[0].a     <= din_a;
            st[0].b     <= din_b;
            st[0].acc   <= '0;
            for (int k = 1; k < NCS; k++) begin
                st[k]     <= st[k-1];
                st[k].acc <= pp[k-1];
            end
            out_valid <= st[NCS-1].valid;
            dout      <= pp[NCS-1];
            out_tag   <= st[NCS-1].tag;
        end
    end

endmodule

// File: tb/tb_pipe_array_mul.sv
// Scoreboard bench for pipe_array_mul: directed vectors, mixed random
// stream with backpressure, mid-flight reset and two parameter variants.
module tb_pipe_array_mul;

    localparam int L = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  din_a = '0;
    logic [7:0]  din_b = '0;
    logic        in_signed = 1'b0;
    logic [3:0]  in_tag = '0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] dout;
    logic [3:0]  out_tag;

    always #5 clk = ~clk;

    pipe_array_mul #(.WIDTH(8), .ROWS_PER_STAGE(2), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .din_a(din_a), .din_b(din_b), .in_signed(in_signed), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
        .out_tag(out_tag)
    );

    logic       v4_valid = 1'b0;
    logic [3:0] v4_a = '0;
    logic [3:0] v4_b = '0;
    logic       v4_sgn = 1'b0;
    logic       v4_in_ready;
    logic       v4_out_valid;
    logic [7:0] v4_dout;
    logic [0:0] v4_tag;

    pipe_array_mul #(.WIDTH(4), .ROWS_PER_STAGE(1), .TAG_W(1)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v4_valid), .in_ready(v4_in_ready),
        .din_a(v4_a), .din_b(v4_b), .in_signed(v4_sgn), .in_tag(1'b1),
        .out_valid(v4_out_valid), .out_ready(1'b1), .dout(v4_dout),
        .out_tag(v4_tag)
    );

    logic       v5_valid = 1'b0;
    logic [4:0] v5_a = '0;
    logic [4:0] v5_b = '0;
    logic       v5_sgn = 1'b0;
    logic       v5_in_ready;
    logic       v5_out_valid;
    logic [9:0] v5_dout;
    logic [1:0] v5_tag;

    pipe_array_mul #(.WIDTH(5), .ROWS_PER_STAGE(2), .TAG_W(2)) dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(v5_valid), .in_ready(v5_in_ready),
        .din_a(v5_a), .din_b(v5_b), .in_signed(v5_sgn), .in_tag(2'd2),
        .out_valid(v5_out_valid), .out_ready(1'b1), .dout(v5_dout),
        .out_tag(v5_tag)
    );

    typedef struct {
        logic [15:0] p;
        logic [3:0]  tag;
        int          due;
        bit          chk;
    } exp_t;

    exp_t q[$];
    exp_t e_m;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   rand_rdy = 1'b0;
    bit   thr_mode = 1'b0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [15:0] ref_mul(input logic [7:0] a,
                                            input logic [7:0] b,
                                            input logic s);
        logic signed [15:0] r;
        if (s) begin
            r = $signed(a) * $signed(b);
            return r;
        end
        return {8'd0, a} * {8'd0, b};
    endfunction

    // Monitor: pops an expectation for every result the consumer takes.
    logic        stall_q = 1'b0;
    logic [15:0] d_q = '0;
    logic [3:0]  t_q = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                tests++;
                if (!out_valid || dout !== d_q || out_tag !== t_q) begin
                    fails++;
                    $display("FAIL hold: valid=%0b dout=%h tag=%h, need 1 %h %h",
                             out_valid, dout, out_tag, d_q, t_q);
                end
            end
            if (out_valid && !out_ready) begin
                tests++;
                if (in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL in_ready_stall: got %b need 0", in_ready);
                end
            end
            if (out_valid && out_ready) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected: dout=%h tag=%h, none expected",
                             dout, out_tag);
                end else begin
                    e_m = q.pop_front();
                    if (dout !== e_m.p || out_tag !== e_m.tag) begin
                        fails++;
                        $display("FAIL result: dout=%h tag=%h, need %h %h",
                                 dout, out_tag, e_m.p, e_m.tag);
                    end
                    if (e_m.chk) begin
                        tests++;
                        if (cyc != e_m.due) begin
                            fails++;
                            $display("FAIL latency: edge %0d, need %0d",
                                     cyc, e_m.due);
                        end
                    end
                end
            end
            stall_q = out_valid && !out_ready;
            d_q = dout;
            t_q = out_tag;
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic [3:0] t,
                        input logic [15:0] exp, input bit push,
                        input bit chk);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        din_a = a;
        din_b = b;
        in_signed = s;
        in_tag = t;
        in_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk);
            n++;
            if (thr_mode) begin
                tests++;
                if (in_ready !== 1'b1) begin
                    fails++;
                    $display("FAIL thr_ready: in_ready=%b need 1", in_ready);
                end
            end
            if (in_ready) begin
                ok = 1'b1;
                if (push) q.push_back('{exp, t, cyc + L, chk});
            end
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready=%b need 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d left, need 0", q.size());
            q.delete();
        end
        #1;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rs;
        logic [3:0] rt;
        bit         found;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || dout !== 16'h0 || out_tag !== 4'h0 ||
            in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: v=%b d=%h t=%h rdy=%b, need 0 0 0 1",
                     out_valid, dout, out_tag, in_ready);
        end
        @(posedge clk);
        #1;

        send(8'd255, 8'd255, 1'b0, 4'd3, 16'hFE01, 1'b1, 1'b1);
        idle();
        drain();
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_cycle: out_valid=%b need 0", out_valid);
        end
        @(posedge clk);
        #1;

        send(8'h80, 8'h80, 1'b1, 4'd5, 16'h4000, 1'b1, 1'b1);
        send(8'hFF, 8'h01, 1'b1, 4'd6, 16'hFFFF, 1'b1, 1'b1);
        send(8'h80, 8'h7F, 1'b1, 4'd7, 16'hC080, 1'b1, 1'b1);
        idle();
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                idle();
                @(posedge clk);
                #1;
            end
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            rt = 4'(i);
            send(ra, rb, rs, rt, ref_mul(ra, rb, rs), 1'b1, 1'b0);
        end
        idle();
        drain();
        rand_rdy = 1'b0;
        @(posedge clk);
        #1;

        thr_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            ra = 8'(i * 7);
            rb = 8'(255 - i);
            rs = 1'(i % 2);
            send(ra, rb, rs, 4'(i), ref_mul(ra, rb, rs), 1'b1, 1'b1);
        end
        thr_mode = 1'b0;
        idle();
        drain();

        send(8'd10, 8'd20, 1'b0, 4'd1, 16'd0, 1'b0, 1'b0);
        send(8'd30, 8'd40, 1'b1, 4'd2, 16'd0, 1'b0, 1'b0);
        send(8'd50, 8'd60, 1'b0, 4'd3, 16'd0, 1'b0, 1'b0);
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (out_valid !== 1'b0 || dout !== 16'h0) begin
            fails++;
            $display("FAIL mid_reset: v=%b d=%h, need 0 0", out_valid, dout);
        end
        repeat (8) @(posedge clk);
        #1;
        send(8'd12, 8'd13, 1'b0, 4'd9, 16'd156, 1'b1, 1'b1);
        idle();
        drain();

        v4_a = 4'd15;
        v4_b = 4'd15;
        v4_sgn = 1'b0;
        v4_valid = 1'b1;
        @(posedge clk);
        #1 v4_valid = 1'b0;
        found = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (v4_out_valid && !found) begin
                found = 1'b1;
                tests++;
                if (v4_dout !== 8'd225 || n != 5) begin
                    fails++;
                    $display("FAIL w4: dout=%0d lat=%0d, need 225 5",
                             v4_dout, n);
                end
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL w4_timeout: no result, need 225");
        end

        @(posedge clk);
        #1;
        v5_a = 5'b10000;
        v5_b = 5'b10000;
        v5_sgn = 1'b1;
        v5_valid = 1'b1;
        @(posedge clk);
        #1 v5_valid = 1'b0;
        found = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (v5_out_valid && !found) begin
                found = 1'b1;
                tests++;
                if (v5_dout !== 10'd256 || n != 4) begin
                    fails++;
                    $display("FAIL w5: dout=%0d lat=%0d, need 256 4",
                             v5_dout, n);
                end
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("FAIL w5_timeout: no result, need 256");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
